icache_dm: RTL
==============

// Module: icache_dm
// PURPOSE
//  Direct-mapped, read-only instruction cache between the core's IMem port (fetch stage) and the
//  backing instruction memory. Hits return in 1 cycle; misses refill a whole line word-by-word over
//  the same enable/ready protocol the core uses, then answer the core. invalidate serves FENCE.I.
// PARAMETERS
//  ADDR_W  32  byte-address width (ADDR_SIZE+1)
//  DATA_W  32  instruction/word width (INSTR_SIZE+1)
//  LINES   16  number of cache lines (power of 2, >=2)
//  WPL     4   words per line (power of 2, >=2)
// PORTS
//  clk            in   1       clock, all state on rising edge
//  reset          in   1       synchronous, active-high
//  imem_rd_addr   in   ADDR_W  core fetch byte address; bits[1:0] ignored
//  imem_rd_enable in   1       core request; held with stable addr until imem_rd_ready
//  imem_rd_data   out  DATA_W  instruction, valid only when imem_rd_ready=1
//  imem_rd_ready  out  1       one-cycle response pulse
//  invalidate     in   1       clear all valid bits
//  mem_rd_addr    out  ADDR_W  backing word address (word-aligned, bits[1:0]=0)
//  mem_rd_enable  out  1       backing request; held with stable addr until mem_rd_ready
//  mem_rd_data    in   DATA_W  backing word, sampled when mem_rd_ready=1
//  mem_rd_ready   in   1       backing response pulse
// BEHAVIOUR
//  - Address split: off=addr[log2(WPL)+1:2], idx=next log2(LINES) bits, tag=remaining upper bits.
//  - Storage: data[LINES*WPL], tag[LINES], valid[LINES]; only valid[] is reset.
//  - Reset: state=IDLE, valid[]=0, imem_rd_ready=0, imem_rd_data=0, mem_rd_enable=0, mem_rd_addr=0.
//  - States: IDLE, REFILL, RESP.
//  - IDLE, enable=1, hit (valid[idx]&&tag match): next cycle ready=1, data=data[idx][off]; stay IDLE.
//    Back-to-back hits: a new request may be sampled the cycle after ready (1 hit per 2 cycles min).
//  - IDLE, enable=1, miss: latch line base addr, cnt=0 -> REFILL; imem_rd_ready stays 0.
//  - REFILL: mem_rd_enable=1, mem_rd_addr=base+4*cnt. On mem_rd_ready: write data[idx][cnt], drop
//    mem_rd_enable for >=1 cycle, cnt++. Words fetched in order 0..WPL-1 (no critical-word-first).
//    After word WPL-1: write tag, set valid[idx] unless invalidate seen during refill -> RESP.
//  - RESP: if imem_rd_enable=1 and addr still maps to the refilled line: ready=1 with word at current
//    off, -> IDLE. Otherwise (core flushed/redirected) no pulse, -> IDLE; new request handled normally.
//  - Refill always completes once started; core dropping enable never aborts a backing transaction.
//  - invalidate: in IDLE/RESP clears all valid[] that cycle; a hit check in the same cycle misses.
//    During REFILL sets a sticky flag so the line in flight is filled but left invalid (still answered).
//  - imem_rd_ready never asserted while enable=0; never two consecutive cycles.
//  - Reset mid-refill: immediate return to IDLE, mem_rd_enable=0 next cycle, late mem_rd_ready ignored.
//  - Index wrap: idx LINES-1 and 0 independent; addresses differing only in tag evict each other.
// TESTING
//  1 reset; fetch 0x0000_0000, backing returns words 0xA0..0xA3 -> 4 mem reqs 0x0,0x4,0x8,0xC, ready with 0xA0.
//  2 after 1, fetch 0x8 -> ready next cycle with 0xA2, no mem_rd_enable.
//  3 fetch 0x0000_0100 (LINES=16,WPL=4: same idx 0, new tag) -> refill, then 0x0 misses again (eviction).
//  4 miss at 0x40, core drops enable during word 2 -> refill finishes, no ready pulse, 0x44 then hits.
//  5 invalidate during refill of 0x80 -> line answered once; refetch 0x80 misses and refills.
//  6 reset asserted mid-refill with mem_rd_ready delayed -> all outputs 0, fetch of 0x0 misses afterwards.

Source files
------------

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache between the fetch stage and backing memory.
// Hits answer one cycle after the request; misses refill the whole line in word order first.
module icache_dm #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINES  = 16,
    parameter int WPL    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] imem_rd_addr,
    input  logic              imem_rd_enable,
    output logic [DATA_W-1:0] imem_rd_data,
    output logic              imem_rd_ready,
    input  logic              invalidate,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic              mem_rd_enable,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_rd_ready
);
    localparam int OFF_W  = $clog2(WPL);
    localparam int IDX_W  = $clog2(LINES);
    localparam int LINE_W = ADDR_W - 2 - OFF_W;
    localparam int TAG_W  = LINE_W - IDX_W;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REFILL = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [OFF_W-1:0]  cnt_q, cnt_d;
    logic              inv_seen_q, inv_seen_d;
    logic              mem_en_q, mem_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              rdy_q, rdy_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [LINES-1:0]  valid_q, valid_d;

    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES*WPL];

    logic [LINE_W-1:0] req_line_s;
    logic [IDX_W-1:0]  req_idx_s, ref_idx_s;
    logic [OFF_W-1:0]  req_off_s;
    logic [TAG_W-1:0]  req_tag_s, ref_tag_s;
    logic [DATA_W-1:0] rd_word_s;
    logic              hit_s, dwe_s, twe_s;

    assign req_line_s = imem_rd_addr[ADDR_W-1:OFF_W+2];
    assign req_idx_s  = imem_rd_addr[OFF_W+2 +: IDX_W];
    assign req_off_s  = imem_rd_addr[2 +: OFF_W];
    assign req_tag_s  = imem_rd_addr[ADDR_W-1 -: TAG_W];
    assign ref_idx_s  = line_q[IDX_W-1:0];
    assign ref_tag_s  = line_q[LINE_W-1:IDX_W];
    assign rd_word_s  = data_mem[{req_idx_s, req_off_s}];
    // An invalidate in the same cycle must turn a would-be hit into a miss.
    assign hit_s      = valid_q[req_idx_s] && (tag_mem[req_idx_s] == req_tag_s) && !invalidate;

    // Next-state and output computation for the IDLE/REFILL/RESP controller.
    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        cnt_d      = cnt_q;
        inv_seen_d = inv_seen_q;
        mem_en_d   = mem_en_q;
        mem_addr_d = mem_addr_q;
        rdy_d      = 1'b0;
        rdata_d    = rdata_q;
        dwe_s      = 1'b0;
        twe_s      = 1'b0;
        if (invalidate) begin
            valid_d = {LINES{1'b0}};
        end else begin
            valid_d = valid_q;
        end
        case (state_q)
            S_IDLE: begin
                // The request that was just answered is still on the bus during the ready cycle.
                if (imem_rd_enable && !rdy_q) begin
                    if (hit_s) begin
                        rdy_d   = 1'b1;
                        rdata_d = rd_word_s;
                    end else begin
                        line_d     = req_line_s;
                        cnt_d      = {OFF_W{1'b0}};
                        inv_seen_d = 1'b0;
                        mem_en_d   = 1'b1;
                        mem_addr_d = {req_line_s, {OFF_W{1'b0}}, 2'b00};
                        state_d    = S_REFILL;
                    end
                end else begin
                    rdy_d = 1'b0;
                end
            end
            S_REFILL: begin
                inv_seen_d = inv_seen_q | invalidate;
                if (mem_en_q) begin
                    if (mem_rd_ready) begin
                        dwe_s    = 1'b1;
                        mem_en_d = 1'b0;
                        cnt_d    = cnt_q + OFF_W'(1);
                        if (cnt_q == OFF_W'(WPL - 1)) begin
                            twe_s   = 1'b1;
                            state_d = S_RESP;
                            if (!inv_seen_q && !invalidate) begin
                                valid_d[ref_idx_s] = 1'b1;
                            end else begin
                                valid_d[ref_idx_s] = 1'b0;
                            end
                        end else begin
                            state_d = S_REFILL;
                        end
                    end else begin
                        mem_en_d = 1'b1;
                    end
                end else begin
                    mem_en_d   = 1'b1;
                    mem_addr_d = {line_q, cnt_q, 2'b00};
                end
            end
            S_RESP: begin
                if (imem_rd_enable && (req_line_s == line_q)) begin
                    rdy_d   = 1'b1;
                    rdata_d = rd_word_s;
                end else begin
                    rdy_d = 1'b0;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                mem_en_d = 1'b0;
            end
        endcase
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            line_q     <= {LINE_W{1'b0}};
            cnt_q      <= {OFF_W{1'b0}};
            inv_seen_q <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= {ADDR_W{1'b0}};
            rdy_q      <= 1'b0;
            rdata_q    <= {DATA_W{1'b0}};
            valid_q    <= {LINES{1'b0}};
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            cnt_q      <= cnt_d;
            inv_seen_q <= inv_seen_d;
            mem_en_q   <= mem_en_d;
            mem_addr_q <= mem_addr_d;
            rdy_q      <= rdy_d;
            rdata_q    <= rdata_d;
            valid_q    <= valid_d;
        end
    end

    // Line storage is not reset; only valid bits qualify its contents.
    always_ff @(posedge clk) begin
        if (dwe_s && !reset) begin
            data_mem[{ref_idx_s, cnt_q}] <= mem_rd_data;
        end
        if (twe_s && !reset) begin
            tag_mem[ref_idx_s] <= ref_tag_s;
        end
    end

    assign imem_rd_data  = rdata_q;
    assign imem_rd_ready = rdy_q;
    assign mem_rd_addr   = mem_addr_q;
    assign mem_rd_enable = mem_en_q;
endmodule
